// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// instruction field layout, reset defaults and branch-offset scaling.
package instr_fetch_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OFF_W = 8;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned     TIMEOUT_DEFAULT  = 255;
  localparam int unsigned     CNT_W_DEFAULT    = 8;

  localparam int unsigned OPCODE_LSB = 24;
  localparam int unsigned DEST_LSB   = 16;
  localparam int unsigned SRC1_LSB   = 8;
  localparam int unsigned SRC2_LSB   = 0;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,
    IF_FETCH   = 2'd1,
    IF_DELIVER = 2'd2,
    IF_ERROR   = 2'd3
  } if_state_e;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] dest;
    logic [7:0] src1;
    logic [7:0] src2;
  } instr_t;

  // Signed word offset scaled to a byte displacement.
  function automatic logic [XLEN-1:0] word_offset(input logic [OFF_W-1:0] off);
    return {{(XLEN-OFF_W-2){off[OFF_W-1]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the instruction-memory request/response and core delivery signals.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic              imem_read;
  logic [XLEN-1:0]   imem_address;
  logic [XLEN-1:0]   imem_readdata;
  logic              imem_busywait;
  instr_t            instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect;
  logic [OFF_W-1:0]  redirect_off;
  logic [XLEN-1:0]   pc;
  logic              fetch_error;

  modport master (
    output imem_read, imem_address, instr, instr_valid, pc, fetch_error,
    input  imem_readdata, imem_busywait, instr_ready, redirect, redirect_off
  );

  modport slave (
    input  imem_read, imem_address, instr, instr_valid, pc, fetch_error,
    output imem_readdata, imem_busywait, instr_ready, redirect, redirect_off
  );

endinterface

// File: rtl/instr_fetch_unit_pc_next_adder.sv
// Next-PC computation: sequential PC+4, or PC+4 plus a signed word offset.
module instr_fetch_unit_pc_next_adder
  import instr_fetch_unit_pkg::*;
(
  input  logic [XLEN-1:0]  pc,
  input  logic             redirect,
  input  logic [OFF_W-1:0] redirect_off,
  output logic [XLEN-1:0]  next_pc_c
);

  logic [XLEN-1:0] seq_pc;

  assign seq_pc    = pc + XLEN'(4);
  assign next_pc_c = redirect ? seq_pc + word_offset(redirect_off) : seq_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch initiator: owns the PC, reads one word at a time from instruction
// memory, holds it for the core, and times out a stuck memory.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     TIMEOUT  = TIMEOUT_DEFAULT,
  parameter int unsigned     CNT_W    = CNT_W_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_unit_if.master bus
);

  if_state_e        state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  instr_t           instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             read_q, read_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  next_pc_c;

  instr_fetch_unit_pc_next_adder u_pc_next_adder (
    .pc           (pc_q),
    .redirect     (bus.redirect),
    .redirect_off (bus.redirect_off),
    .next_pc_c    (next_pc_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IF_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      read_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      read_q  <= read_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and next-register values; everything holds unless a case moves it.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    read_d  = read_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      IF_IDLE: begin
        read_d  = 1'b1;
        state_d = IF_FETCH;
      end
      IF_FETCH: begin
        if (!bus.imem_busywait) begin
          instr_d = instr_t'(bus.imem_readdata);
          valid_d = 1'b1;
          read_d  = 1'b0;
          cnt_d   = '0;
          state_d = IF_DELIVER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // Trip on the TIMEOUT-th consecutive busy cycle.
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            read_d  = 1'b0;
            state_d = IF_ERROR;
          end
        end
      end
      IF_DELIVER: begin
        if (bus.instr_ready) begin
          valid_d = 1'b0;
          read_d  = 1'b1;
          pc_d    = next_pc_c;
          state_d = IF_FETCH;
        end
      end
      IF_ERROR: begin
        state_d = IF_ERROR;
      end
      default: begin
        state_d = IF_ERROR;
      end
    endcase
  end

  assign bus.imem_read    = read_q;
  assign bus.imem_address = pc_q;
  assign bus.instr        = instr_q;
  assign bus.instr_valid  = valid_q;
  assign bus.pc           = pc_q;
  assign bus.fetch_error  = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// fetch/stall/redirect transactions against a transaction-level PC model.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_pc;

  instr_fetch_unit_if bus();
  instr_fetch_unit_if bus2();

  instr_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: sequential word, or word after it plus a signed word offset.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic r,
                                             input logic [7:0] off);
    int delta;
    delta = r ? 4 * int'($signed(off)) : 0;
    return pc + 32'(4 + delta);
  endfunction

  // One fetch: busy cycles, delivery, stall (with ignored redirects), accept.
  task automatic txn(input int busy, input int stall, input logic r,
                     input logic [7:0] off, input logic [31:0] data);
    chk("fetch_read", 32'(bus.imem_read), 32'd1);
    chk("fetch_addr", bus.imem_address, exp_pc);
    chk("fetch_valid_low", 32'(bus.instr_valid), 32'd0);
    repeat (busy) begin
      bus.imem_busywait = 1'b1;
      bus.imem_readdata = $urandom;
      step();
      chk("busy_read_held", 32'(bus.imem_read), 32'd1);
      chk("busy_addr_held", bus.imem_address, exp_pc);
    end
    bus.imem_busywait = 1'b0;
    bus.imem_readdata = data;
    step();
    bus.imem_busywait = 1'($urandom);
    bus.imem_readdata = $urandom;
    chk("deliver_instr", bus.instr, data);
    chk("deliver_valid", 32'(bus.instr_valid), 32'd1);
    chk("deliver_pc", bus.pc, exp_pc);
    chk("deliver_read_low", 32'(bus.imem_read), 32'd0);
    repeat (stall) begin
      bus.instr_ready  = 1'b0;
      bus.redirect     = 1'($urandom);
      bus.redirect_off = 8'($urandom);
      step();
      chk("stall_instr", bus.instr, data);
      chk("stall_pc", bus.pc, exp_pc);
      chk("stall_valid", 32'(bus.instr_valid), 32'd1);
    end
    bus.instr_ready  = 1'b1;
    bus.redirect     = r;
    bus.redirect_off = off;
    step();
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    exp_pc = model_next(exp_pc, r, off);
    chk("accept_read", 32'(bus.imem_read), 32'd1);
    chk("accept_valid_low", 32'(bus.instr_valid), 32'd0);
    chk("accept_addr", bus.imem_address, exp_pc);
  endtask

  task automatic check_reset_state();
    chk("rst_read", 32'(bus.imem_read), 32'd0);
    chk("rst_addr", bus.imem_address, 32'h0);
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_err", 32'(bus.fetch_error), 32'd0);
  endtask

  initial begin
    bus.imem_readdata  = '0;
    bus.imem_busywait  = 1'b0;
    bus.instr_ready    = 1'b0;
    bus.redirect       = 1'b0;
    bus.redirect_off   = '0;
    bus2.imem_readdata = '0;
    bus2.imem_busywait = 1'b0;
    bus2.instr_ready   = 1'b0;
    bus2.redirect      = 1'b0;
    bus2.redirect_off  = '0;

    // Reset pulse of 6 ns, then first fetch with two busy cycles.
    #1;
    check_reset_state();
    #5 rst = 1'b0;
    step();
    exp_pc = 32'h0;
    txn(2, 0, 1'b0, 8'h00, 32'h0004_0005);

    // Back-to-back sequential fetches 4, 8, C.
    txn(0, 0, 1'b0, 8'h00, 32'h1111_0004);
    txn(0, 0, 1'b0, 8'h00, 32'h2222_0008);
    txn(0, 0, 1'b0, 8'h00, 32'h3333_000C);

    // At pc 0x10: ignored redirects while stalled, then redirect by -2 words.
    chk("pc_before_redirect", exp_pc, 32'h10);
    txn(0, 2, 1'b1, 8'hFE, 32'h4444_0010);
    chk("redirect_target", bus.imem_address, 32'h0000_000C);

    // Randomized transactions.
    for (int i = 0; i < 30; i++) begin
      txn(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'($urandom),
          8'($urandom), $urandom);
    end

    // Memory timeout: 254 busy cycles survive, the 255th trips the error.
    bus.imem_busywait = 1'b1;
    repeat (254) step();
    chk("timeout_not_yet_err", 32'(bus.fetch_error), 32'd0);
    chk("timeout_not_yet_read", 32'(bus.imem_read), 32'd1);
    step();
    chk("timeout_err", 32'(bus.fetch_error), 32'd1);
    chk("timeout_read_low", 32'(bus.imem_read), 32'd0);
    for (int i = 0; i < 6; i++) begin
      bus.imem_busywait = 1'(i);
      bus.instr_ready   = 1'b1;
      bus.redirect      = 1'b1;
      bus.redirect_off  = 8'($urandom);
      step();
      chk("error_frozen_err", 32'(bus.fetch_error), 32'd1);
      chk("error_frozen_read", 32'(bus.imem_read), 32'd0);
      chk("error_frozen_addr", bus.imem_address, exp_pc);
      chk("error_frozen_valid", 32'(bus.instr_valid), 32'd0);
    end
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_state();
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    exp_pc = 32'h0;
    txn(1, 1, 1'b0, 8'h00, $urandom);
    txn(0, 0, 1'b1, 8'h03, $urandom);

    // Reset raised between edges while a fetch is pending.
    bus.imem_busywait = 1'b1;
    step();
    chk("pre_midreset_read", 32'(bus.imem_read), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midreset_read", 32'(bus.imem_read), 32'd0);
    chk("midreset_valid", 32'(bus.instr_valid), 32'd0);
    chk("midreset_addr", bus.imem_address, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.imem_busywait = 1'b0;
    step();
    exp_pc = 32'h0;
    txn(0, 0, 1'b0, 8'h00, 32'hCAFE_0000);

    // Top-of-memory wrap on the instance reset to 0xFFFF_FFFC.
    rst = 1'b1;
    #1;
    chk("wrap_rst_pc", bus2.pc, 32'hFFFF_FFFC);
    chk("wrap_rst_addr", bus2.imem_address, 32'hFFFF_FFFC);
    @(posedge clk);
    #1 rst = 1'b0;
    bus2.imem_busywait = 1'b0;
    bus2.imem_readdata = 32'h0102_0304;
    step();
    chk("wrap_fetch_read", 32'(bus2.imem_read), 32'd1);
    chk("wrap_fetch_addr", bus2.imem_address, 32'hFFFF_FFFC);
    step();
    chk("wrap_instr", bus2.instr, 32'h0102_0304);
    chk("wrap_valid", 32'(bus2.instr_valid), 32'd1);
    bus2.instr_ready = 1'b1;
    step();
    bus2.instr_ready = 1'b0;
    chk("wrap_next_addr", bus2.imem_address, 32'h0000_0000);
    chk("wrap_next_read", 32'(bus2.imem_read), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
